// File: rtl/vga_frame_data_sync_pkg.sv
// vga_frame_data_sync_pkg
// Shared definitions for the rover frame data path. The VGA writer imports
// this package too, so field widths and the frame bundle live here.
//   LOC_W / CMD_W / ORIENT_W / TARGET_W : widths of the rover fields
//   rover_frame_t                       : the four fields as one bundle
//   sat_inc8                            : 8-bit increment that sticks at 255
package vga_frame_data_sync_pkg;

    localparam int LOC_W    = 12;
    localparam int CMD_W    = 12;
    localparam int ORIENT_W = 6;
    localparam int TARGET_W = 4;

    typedef struct packed {
        logic [LOC_W-1:0]    location;
        logic [CMD_W-1:0]    move_command;
        logic [ORIENT_W-1:0] orientation;
        logic [TARGET_W-1:0] target_location;
    } rover_frame_t;

    // Counter increment that holds at the top value instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/vga_frame_data_sync_frame_tick_gen.sv
// frame_tick_gen
// Detects the falling edge of the active-low vsync, producing a single-cycle
// frame_tick in the first cycle vsync is sampled low.
//   vclock     : pixel clock
//   reset      : synchronous, active-high
//   vsync      : active-low vertical sync, already in the vclock domain
//   frame_tick : high for one cycle at the start of vertical sync
module frame_tick_gen (
    input  logic vclock,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_prev;

    // Previous vsync sample. Clearing it on reset means a vsync that is
    // already low when reset releases does not look like a new frame.
    always_ff @(posedge vclock) begin
        if (reset) begin
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= vsync;
        end
    end

    // High-to-low transition between last cycle and this one.
    assign frame_tick = vsync_prev & ~vsync;

endmodule

// File: rtl/vga_frame_data_sync.sv
// vga_frame_data_sync
// Sits in front of the VGA writer. Tracking/control logic hands over rover
// samples at any time through valid/ready; the latest one is parked in a
// pending register and only copied to the outputs at the start of vsync, so
// the writer sees fields that are constant for a whole frame.
//   vclock, reset                  : pixel clock, synchronous active-high reset
//   in_valid / in_ready            : upstream sample handshake
//   in_location .. in_target_location : sample fields
//   vsync                          : active-low vertical sync
//   location .. target_location    : frame-stable fields
//   new_data                       : one-cycle pulse when fields were updated
//   frames_since_update            : frames since last commit, saturating
//   stale                          : frames_since_update >= STALE_FRAMES
module vga_frame_data_sync
    import vga_frame_data_sync_pkg::*;
#(
    parameter bit               OVERWRITE      = 1'b1,
    parameter int               STALE_FRAMES   = 60,
    parameter logic [LOC_W-1:0] RESET_LOCATION = 12'h000
) (
    input  logic                vclock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LOC_W-1:0]    in_location,
    input  logic [CMD_W-1:0]    in_move_command,
    input  logic [ORIENT_W-1:0] in_orientation,
    input  logic [TARGET_W-1:0] in_target_location,
    input  logic                vsync,
    output logic [LOC_W-1:0]    location,
    output logic [CMD_W-1:0]    move_command,
    output logic [ORIENT_W-1:0] orientation,
    output logic [TARGET_W-1:0] target_location,
    output logic                new_data,
    output logic [7:0]          frames_since_update,
    output logic                stale
);

    localparam logic [7:0] STALE_LIMIT = 8'(STALE_FRAMES);

    rover_frame_t sample;
    rover_frame_t pending;
    rover_frame_t committed;
    logic         pending_valid;
    logic         frame_tick;
    logic         accept;
    logic         commit;
    logic [7:0]   frames_next;

    frame_tick_gen u_frame_tick_gen (
        .vclock     (vclock),
        .reset      (reset),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    // With OVERWRITE the slot is always open and the newest sample wins;
    // otherwise the slot blocks until its contents have been committed.
    generate
        if (OVERWRITE) begin : g_overwrite
            assign in_ready = 1'b1;
        end else begin : g_blocking
            assign in_ready = ~pending_valid;
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign commit = frame_tick & pending_valid;

    // Bundle the incoming fields and work out the next frame counter value.
    always_comb begin
        sample.location        = in_location;
        sample.move_command    = in_move_command;
        sample.orientation     = in_orientation;
        sample.target_location = in_target_location;
        frames_next            = frames_since_update;
        if (commit) begin
            frames_next = 8'd0;
        end else if (frame_tick) begin
            frames_next = sat_inc8(frames_since_update);
        end
    end

    // Pending slot and committed outputs. A sample accepted on the tick edge
    // lands in pending while the older pending value is committed, so it
    // waits for the following frame.
    always_ff @(posedge vclock) begin
        if (reset) begin
            pending             <= '0;
            pending_valid       <= 1'b0;
            committed           <= '{location: RESET_LOCATION, default: '0};
            new_data            <= 1'b0;
            frames_since_update <= 8'd0;
            stale               <= 1'b0;
        end else begin
            if (accept) begin
                pending <= sample;
            end
            pending_valid <= accept | (pending_valid & ~frame_tick);
            if (commit) begin
                committed <= pending;
            end
            new_data            <= commit;
            frames_since_update <= frames_next;
            stale               <= (frames_next >= STALE_LIMIT);
        end
    end

    assign location        = committed.location;
    assign move_command    = committed.move_command;
    assign orientation     = committed.orientation;
    assign target_location = committed.target_location;

endmodule

// File: tb/tb_vga_frame_data_sync.sv
// tb_vga_frame_data_sync
// Directed bench for vga_frame_data_sync. One instance uses the default
// overwrite behaviour, a second uses the blocking slot with a non-zero reset
// location. Both share clock, reset, vsync and the sample inputs.
module tb_vga_frame_data_sync;

    logic        vclock = 1'b0;
    logic        reset;
    logic        inValid;
    logic [11:0] inLocation;
    logic [11:0] inMoveCommand;
    logic [5:0]  inOrientation;
    logic [3:0]  inTargetLocation;
    logic        vsync;

    logic        inReady;
    logic [11:0] location;
    logic [11:0] moveCommand;
    logic [5:0]  orientation;
    logic [3:0]  targetLocation;
    logic        newData;
    logic [7:0]  framesSinceUpdate;
    logic        stale;

    logic        blkInReady;
    logic [11:0] blkLocation;
    logic [11:0] blkMoveCommand;
    logic [5:0]  blkOrientation;
    logic [3:0]  blkTargetLocation;
    logic        blkNewData;
    logic [7:0]  blkFramesSinceUpdate;
    logic        blkStale;

    int passCount = 0;
    int failCount = 0;
    int totalCount = 0;

    // 65 MHz is approximated by a 10-unit period; only cycle order matters.
    always #5 vclock = ~vclock;

    vga_frame_data_sync dut (
        .vclock              (vclock),
        .reset               (reset),
        .in_valid            (inValid),
        .in_ready            (inReady),
        .in_location         (inLocation),
        .in_move_command     (inMoveCommand),
        .in_orientation      (inOrientation),
        .in_target_location  (inTargetLocation),
        .vsync               (vsync),
        .location            (location),
        .move_command        (moveCommand),
        .orientation         (orientation),
        .target_location     (targetLocation),
        .new_data            (newData),
        .frames_since_update (framesSinceUpdate),
        .stale               (stale)
    );

    vga_frame_data_sync #(
        .OVERWRITE      (1'b0),
        .STALE_FRAMES   (60),
        .RESET_LOCATION (12'h7E7)
    ) dutBlk (
        .vclock              (vclock),
        .reset               (reset),
        .in_valid            (inValid),
        .in_ready            (blkInReady),
        .in_location         (inLocation),
        .in_move_command     (inMoveCommand),
        .in_orientation      (inOrientation),
        .in_target_location  (inTargetLocation),
        .vsync               (vsync),
        .location            (blkLocation),
        .move_command        (blkMoveCommand),
        .orientation         (blkOrientation),
        .target_location     (blkTargetLocation),
        .new_data            (blkNewData),
        .frames_since_update (blkFramesSinceUpdate),
        .stale               (blkStale)
    );

    // Advance one clock and settle just after the edge.
    task automatic stepCycle();
        @(posedge vclock);
        #1;
    endtask

    // Drive the upstream sample interface.
    task automatic applyStimulus(input logic valid, input logic [11:0] loc,
                                 input logic [11:0] cmd, input logic [5:0] orient,
                                 input logic [3:0] target);
        inValid          = valid;
        inLocation       = loc;
        inMoveCommand    = cmd;
        inOrientation    = orient;
        inTargetLocation = target;
    endtask

    // vsync high for one edge, then low; returns just after the commit edge.
    task automatic runFrame();
        vsync = 1'b1;
        stepCycle();
        vsync = 1'b0;
        stepCycle();
    endtask

    // One comparison with pass/fail bookkeeping.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence following the block's test plan.
    initial begin
        reset = 1'b1;
        vsync = 1'b0;
        applyStimulus(1'b0, 12'h000, 12'h000, 6'd0, 4'd0);
        repeat (3) stepCycle();
        reset = 1'b0;
        repeat (3) stepCycle();

        $display("[TB] reset with vsync low");
        checkOutput("rst_new_data", 32'(newData), 32'd0);
        checkOutput("rst_location", 32'(location), 32'h000);
        checkOutput("rst_in_ready", 32'(inReady), 32'd1);
        checkOutput("rst_frames", 32'(framesSinceUpdate), 32'd0);
        checkOutput("rst_stale", 32'(stale), 32'd0);
        checkOutput("rst_blk_location", 32'(blkLocation), 32'h7E7);
        checkOutput("rst_blk_in_ready", 32'(blkInReady), 32'd1);

        $display("[TB] single sample commit");
        applyStimulus(1'b1, 12'h3A5, 12'h5C3, 6'd17, 4'd9);
        stepCycle();
        applyStimulus(1'b0, 12'h3A5, 12'h5C3, 6'd17, 4'd9);
        checkOutput("mid_frame_location", 32'(location), 32'h000);
        checkOutput("blk_full_in_ready", 32'(blkInReady), 32'd0);
        runFrame();
        checkOutput("commit_location", 32'(location), 32'h3A5);
        checkOutput("commit_orientation", 32'(orientation), 32'd17);
        checkOutput("commit_move_command", 32'(moveCommand), 32'h5C3);
        checkOutput("commit_target", 32'(targetLocation), 32'd9);
        checkOutput("commit_new_data", 32'(newData), 32'd1);
        checkOutput("commit_frames", 32'(framesSinceUpdate), 32'd0);
        checkOutput("commit_blk_location", 32'(blkLocation), 32'h3A5);
        stepCycle();
        checkOutput("new_data_pulse_end", 32'(newData), 32'd0);
        checkOutput("location_held", 32'(location), 32'h3A5);
        checkOutput("blk_in_ready_reopen", 32'(blkInReady), 32'd1);

        $display("[TB] two samples in one frame");
        applyStimulus(1'b1, 12'h111, 12'h001, 6'd1, 4'd1);
        stepCycle();
        applyStimulus(1'b1, 12'h222, 12'h002, 6'd2, 4'd2);
        stepCycle();
        checkOutput("blk_stall_1", 32'(blkInReady), 32'd0);
        stepCycle();
        checkOutput("blk_stall_2", 32'(blkInReady), 32'd0);
        runFrame();
        checkOutput("ovw_location", 32'(location), 32'h222);
        checkOutput("ovw_new_data", 32'(newData), 32'd1);
        checkOutput("blk_first_location", 32'(blkLocation), 32'h111);
        checkOutput("blk_ready_after_commit", 32'(blkInReady), 32'd1);
        stepCycle();
        applyStimulus(1'b0, 12'h222, 12'h002, 6'd2, 4'd2);
        checkOutput("blk_second_accepted", 32'(blkInReady), 32'd0);
        runFrame();
        checkOutput("blk_second_location", 32'(blkLocation), 32'h222);
        checkOutput("blk_second_new_data", 32'(blkNewData), 32'd1);

        $display("[TB] accept on the tick edge");
        applyStimulus(1'b1, 12'h00F, 12'h0AA, 6'd3, 4'd3);
        stepCycle();
        applyStimulus(1'b0, 12'h00F, 12'h0AA, 6'd3, 4'd3);
        stepCycle();
        vsync = 1'b1;
        stepCycle();
        vsync = 1'b0;
        applyStimulus(1'b1, 12'h0F0, 12'h0BB, 6'd4, 4'd4);
        stepCycle();
        applyStimulus(1'b0, 12'h0F0, 12'h0BB, 6'd4, 4'd4);
        checkOutput("tick_edge_old_location", 32'(location), 32'h00F);
        checkOutput("tick_edge_new_data", 32'(newData), 32'd1);
        stepCycle();
        checkOutput("tick_edge_hold", 32'(location), 32'h00F);
        runFrame();
        checkOutput("next_frame_location", 32'(location), 32'h0F0);
        checkOutput("next_frame_new_data", 32'(newData), 32'd1);
        checkOutput("next_frame_frames", 32'(framesSinceUpdate), 32'd0);

        $display("[TB] stale and saturation");
        for (int i = 1; i <= 300; i++) begin
            runFrame();
            if (i == 59) begin
                checkOutput("frames_59", 32'(framesSinceUpdate), 32'd59);
                checkOutput("stale_59", 32'(stale), 32'd0);
            end
            if (i == 60) begin
                checkOutput("frames_60", 32'(framesSinceUpdate), 32'd60);
                checkOutput("stale_60", 32'(stale), 32'd1);
            end
            if (i == 255) begin
                checkOutput("frames_255", 32'(framesSinceUpdate), 32'd255);
            end
            if (i == 300) begin
                checkOutput("frames_300", 32'(framesSinceUpdate), 32'd255);
                checkOutput("stale_300", 32'(stale), 32'd1);
                checkOutput("no_commit_new_data", 32'(newData), 32'd0);
            end
        end
        applyStimulus(1'b1, 12'h456, 12'h0CC, 6'd5, 4'd5);
        stepCycle();
        applyStimulus(1'b0, 12'h456, 12'h0CC, 6'd5, 4'd5);
        runFrame();
        checkOutput("fresh_frames", 32'(framesSinceUpdate), 32'd0);
        checkOutput("fresh_stale", 32'(stale), 32'd0);
        checkOutput("fresh_location", 32'(location), 32'h456);

        $display("[TB] reset discards pending sample");
        applyStimulus(1'b1, 12'hABC, 12'h0DD, 6'd6, 4'd6);
        stepCycle();
        applyStimulus(1'b0, 12'hABC, 12'h0DD, 6'd6, 4'd6);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("mid_rst_location", 32'(location), 32'h000);
        checkOutput("mid_rst_frames", 32'(framesSinceUpdate), 32'd0);
        checkOutput("mid_rst_blk_in_ready", 32'(blkInReady), 32'd1);
        runFrame();
        checkOutput("post_rst_new_data", 32'(newData), 32'd0);
        checkOutput("post_rst_location", 32'(location), 32'h000);
        checkOutput("post_rst_blk_location", 32'(blkLocation), 32'h7E7);
        checkOutput("post_rst_frames", 32'(framesSinceUpdate), 32'd1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/vga_frame_data_sync.md
Name: vga_frame_data_sync

Overview:
- Sits directly upstream of the VGA writer.
- Accepts rover location, move command, orientation and target location from the tracking/control logic at arbitrary times through a valid/ready handshake.
- Holds the latest sample in a pending register and commits it to frame-stable outputs only at the start of vertical sync, so the writer never sees fields change mid-frame.
- Drives the writer's new_data strobe and reports how long it has been since fresh tracking data arrived.

Parameters:
- OVERWRITE, 1: 1 = newest sample replaces an uncommitted pending sample (in_ready tied high); 0 = pending slot blocks until committed.
- STALE_FRAMES, 60: number of frames without a commit after which stale asserts.
- RESET_LOCATION, 12'h000: value driven on location after reset.

Ports:
- vclock  in  1  65 MHz pixel clock; the only clock.
- reset  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_location  in  12  rover location.
- in_move_command  in  12  move command to rover.
- in_orientation  in  6  rover orientation.
- in_target_location  in  4  target location from switches.
- vsync  in  1  XVGA vertical sync, active low, generated in the vclock domain.
- location  out  12  frame-stable location.
- move_command  out  12  frame-stable move command.
- orientation  out  6  frame-stable orientation.
- target_location  out  4  frame-stable target location.
- new_data  out  1  one-cycle pulse: outputs were just updated.
- frames_since_update  out  8  frames since last commit, saturating.
- stale  out  1  frames_since_update >= STALE_FRAMES.

Behaviour:
- Reset is synchronous, active-high, on the vclock edge. It forces:
  - location = RESET_LOCATION; move_command, orientation, target_location = 0
  - new_data = 0, frames_since_update = 0, stale = 0
  - pending_valid = 0, vsync_prev = 0
- Reset mid-operation discards any pending sample.
- vsync_prev resets to 0, so a vsync already low at reset release produces no tick.

Frame tick:
- frame_tick = vsync_prev & ~vsync, i.e. the first cycle vsync is sampled low.
- vsync_prev <= vsync every cycle.

Accept:
- A sample is accepted when in_valid & in_ready at the clock edge. All four fields load into pending and pending_valid <= 1.
- OVERWRITE=1: in_ready = 1 always (reset included); a newer sample overwrites the uncommitted pending sample.
- OVERWRITE=0: in_ready = ~pending_valid, a function of registered state only.

Commit, on the edge where frame_tick = 1:
- If pending_valid = 1:
  - Outputs <= pending fields.
  - new_data <= 1 for exactly one cycle. It is visible in the same cycle as the updated outputs, 1 cycle after the tick cycle.
  - pending_valid <= 0 unless a sample is accepted on this same edge.
  - frames_since_update <= 0.
- If pending_valid = 0:
  - Outputs hold; new_data stays 0.
  - frames_since_update <= min(frames_since_update+1, 255).
- Outside frame_tick, new_data <= 0.

Simultaneous accept and frame_tick:
- The committed value is the pending contents from before this edge.
- The newly accepted sample goes into pending (pending_valid = 1) and waits for the next frame.

Stale and width rules:
- stale is registered and updates in the same cycle as frames_since_update.
- frames_since_update is 8-bit and saturates at 255 with no wrap.
- The STALE_FRAMES comparison is unsigned and 8-bit wide. STALE_FRAMES must be in 1..255.

Throughput and state:
- At most one commit per frame. Outputs change only in the cycle after a tick.
- State is captured by pending_valid (EMPTY/FULL) crossed with the frame_tick event. No further FSM is needed.

Decomposition:
- Shared package holds the field widths LOC_W=12, CMD_W=12, ORIENT_W=6, TARGET_W=4 and a rover_frame_t bundle of the four fields. The VGA writer reuses these.
- One natural sub-module: frame_tick_gen, the vsync falling-edge detector with reset-safe prev register. The pixel-side overlay logic reuses it.

Test Plan:
1. Reset with vsync held low, release -> no new_data, location=000, in_ready=1, frames_since_update=0.
2. Accept loc=12'h3A5, orient=6'd17 mid-frame, then vsync 1->0 -> location/orientation update exactly 1 cycle after the tick cycle, new_data high 1 cycle, counter=0.
3. OVERWRITE=1: accept 12'h111 then 12'h222 in the same frame -> commit shows 12'h222. OVERWRITE=0: second sample stalled (in_ready=0) until the commit, then commits next frame.
4. in_valid with 12'h0F0 on the exact frame_tick edge while pending holds 12'h00F -> this frame commits 12'h00F, next frame commits 12'h0F0.
5. No samples for 60 ticks -> stale rises with counter=60. Continue to 300 ticks -> counter saturates at 255. One sample plus tick -> counter=0, stale=0.
6. Reset asserted with a pending sample, then a tick -> no commit and no new_data, outputs remain at reset values.
